// File: rtl/instr_sequencer.sv
// instr_sequencer: per-sample instruction sequencer for the block datapath.
// Holds the block program in an internal instruction RAM. On an accepted
// sample tick it streams instructions 0..len-1 to the decoder, honouring
// stall. It then drains for DRAIN_CYCLES and pulses done.
// Program loads are accepted only while idle. A write attempted while busy
// is dropped, and prog_err pulses.
// Optional feature: define SEQ_OVERRUN_DETECT_EN to enable the sticky
// overrun flag. This flag records a sample tick that arrived while a frame
// was still running.
module instr_sequencer #(
    parameter int INSTR_WIDTH  = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic [ADDR_WIDTH:0]    n_instrs,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   done,
    output logic                   prog_err,
    output logic                   overrun
);

    // Drain counter counts down to zero. An empty program enters the drain
    // one count higher, so that its timing matches a program of length 0
    // that skips the fetch cycle.
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 2);
    localparam logic [CNT_W-1:0] DRAIN_FROM_RUN  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_FROM_IDLE = CNT_W'(DRAIN_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    prog_err_q, prog_err_d;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_s;
    logic                    we_s;
    logic                    accept_s;
    logic                    last_s;

    logic [INSTR_WIDTH-1:0]  mem [DEPTH];

    assign we_s     = prog_we && (state_q == S_IDLE);
    assign accept_s = valid_q && !stall;
    assign last_s   = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // Next-state, program counter, drain counter and RAM read address.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        rd_addr_s = pc_q;
        case (state_q)
            S_IDLE: begin
                rd_addr_s = '0;
                if (sample_tick) begin
                    len_d = n_instrs;
                    pc_d  = '0;
                    if (n_instrs == '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_FROM_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                rd_addr_s = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (accept_s) begin
                    if (last_s) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_FROM_RUN;
                    end else begin
                        pc_d      = pc_q + PC_ONE;
                        rd_addr_s = pc_q + PC_ONE;
                    end
                end else begin
                    rd_addr_s = pc_q;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so that they leave the flops aligned with it.
    always_comb begin
        valid_d    = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DRAIN) && (cnt_d == '0);
        prog_err_d = prog_we && (state_q != S_IDLE);
    end

    // Control and output registers. Reset aborts the frame immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            prog_err_q <= prog_err_d;
        end
    end

    // Instruction RAM array write port. Contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Synchronous RAM read register, which drives instr_out directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
        end else begin
            instr_q <= mem[rd_addr_s];
        end
    end

`ifdef SEQ_OVERRUN_DETECT_EN
    logic overrun_q, overrun_d;

    // Overrun sets on a tick while busy and clears on the next tick accepted in idle.
    always_comb begin
        overrun_d = overrun_q;
        if (sample_tick) begin
            if (state_q == S_IDLE) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Sticky overrun register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. Cycle index k counts clock edges
// after the tick cycle T. Outputs are sampled 1 ns after each rising edge.
module tb_instr_sequencer;

    logic        clk;
    logic        reset_n;
    logic        sample_tick;
    logic [8:0]  n_instrs;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        stall;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        prog_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    logic [31:0] words [0:5];

`ifdef SEQ_OVERRUN_DETECT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    instr_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .n_instrs    (n_instrs),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .stall       (stall),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .prog_err    (prog_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    // Tick in the current cycle T; returns sampled at T+1.
    task automatic start(input logic [8:0] len);
        sample_tick = 1'b1; n_instrs = len;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({instr_out, instr_valid, pc, busy, done, prog_err, overrun} !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {instr_out, instr_valid, pc, busy, done, prog_err, overrun});
        end
        step(); step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) load(i[7:0], words[i]);
    endtask

    task automatic test_basic();
        logic ev, eb, ed;
        start(9'd4);
        n_instrs = 9'd7;
        for (int k = 1; k <= 9; k++) begin
            ev = (k >= 2 && k <= 5); eb = (k <= 7); ed = (k == 7);
            checks++;
            if (instr_valid !== ev) begin errors++; $display("FAIL basic_valid k=%0d got %b exp %b", k, instr_valid, ev); end
            checks++;
            if (busy !== eb) begin errors++; $display("FAIL basic_busy k=%0d got %b exp %b", k, busy, eb); end
            checks++;
            if (done !== ed) begin errors++; $display("FAIL basic_done k=%0d got %b exp %b", k, done, ed); end
            if (ev) begin
                checks++;
                if (instr_out !== words[k-2]) begin errors++; $display("FAIL basic_data k=%0d got %h exp %h", k, instr_out, words[k-2]); end
                checks++;
                if (pc !== 8'(k-2)) begin errors++; $display("FAIL basic_pc k=%0d got %0d exp %0d", k, pc, k-2); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic ev;
        logic [7:0] ep;
        start(9'd4);
        for (int k = 1; k <= 11; k++) begin
            stall = (k == 1) || (k >= 3 && k <= 5);
            ev = (k >= 2 && k <= 8);
            ep = (k == 2) ? 8'd0 : (k <= 6) ? 8'd1 : (k == 7) ? 8'd2 : 8'd3;
            checks++;
            if (instr_valid !== ev) begin errors++; $display("FAIL stall_valid k=%0d got %b exp %b", k, instr_valid, ev); end
            checks++;
            if (done !== (k == 10)) begin errors++; $display("FAIL stall_done k=%0d got %b exp %b", k, done, k == 10); end
            checks++;
            if (busy !== (k <= 10)) begin errors++; $display("FAIL stall_busy k=%0d got %b exp %b", k, busy, k <= 10); end
            if (ev) begin
                checks++;
                if (pc !== ep) begin errors++; $display("FAIL stall_pc k=%0d got %0d exp %0d", k, pc, ep); end
                checks++;
                if (instr_out !== words[ep]) begin errors++; $display("FAIL stall_data k=%0d got %h exp %h", k, instr_out, words[ep]); end
            end
            step();
        end
        stall = 1'b0;
    endtask

    task automatic test_zero();
        start(9'd0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL zero_valid k=%0d got %b exp 0", k, instr_valid); end
            checks++;
            if (done !== (k == 3)) begin errors++; $display("FAIL zero_done k=%0d got %b exp %b", k, done, k == 3); end
            checks++;
            if (busy !== (k <= 3)) begin errors++; $display("FAIL zero_busy k=%0d got %b exp %b", k, busy, k <= 3); end
            step();
        end
    endtask

    task automatic test_prog_err();
        start(9'd4);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin prog_we = 1'b1; prog_addr = 8'd5; prog_data = 32'hDEAD_BEEF; end
            else begin prog_we = 1'b0; end
            checks++;
            if (prog_err !== (k == 4)) begin errors++; $display("FAIL prog_err k=%0d got %b exp %b", k, prog_err, k == 4); end
            step();
        end
        prog_we = 1'b0;
        start(9'd6);
        for (int k = 1; k <= 10; k++) begin
            if (k >= 2 && k <= 7) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_out !== words[k-2]) begin
                    errors++; $display("FAIL ram_keep k=%0d got %b/%h exp 1/%h", k, instr_valid, instr_out, words[k-2]);
                end
            end
            step();
        end
    endtask

    task automatic test_write_tick();
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'h99;
        start(9'd1);
        prog_we = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (instr_valid !== (k == 2)) begin errors++; $display("FAIL wt_valid k=%0d got %b exp %b", k, instr_valid, k == 2); end
            if (k == 2) begin
                checks++;
                if (instr_out !== 32'h99) begin errors++; $display("FAIL wt_data got %h exp 99", instr_out); end
            end
            checks++;
            if (done !== (k == 4)) begin errors++; $display("FAIL wt_done k=%0d got %b exp %b", k, done, k == 4); end
            step();
        end
        load(8'd0, words[0]);
    endtask

    task automatic test_overrun();
        logic eo;
        start(9'd4);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin sample_tick = 1'b1; n_instrs = 9'd2; end
            else begin sample_tick = 1'b0; end
            eo = OVR_EN && (k >= 4);
            checks++;
            if (overrun !== eo) begin errors++; $display("FAIL overrun_set k=%0d got %b exp %b", k, overrun, eo); end
            checks++;
            if (instr_valid !== (k >= 2 && k <= 5)) begin errors++; $display("FAIL ovr_valid k=%0d got %b", k, instr_valid); end
            checks++;
            if (done !== (k == 7)) begin errors++; $display("FAIL ovr_done k=%0d got %b exp %b", k, done, k == 7); end
            step();
        end
        checks++;
        if (overrun !== OVR_EN) begin errors++; $display("FAIL overrun_idle got %b exp %b", overrun, OVR_EN); end
        start(9'd4);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", overrun); end
        for (int k = 2; k <= 9; k++) step();
    endtask

    task automatic test_reset_mid();
        start(9'd4);
        step(); step(); step();
        checks++;
        if (pc !== 8'd2 || instr_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got pc %0d v %b exp 2 1", pc, instr_valid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({instr_out, instr_valid, pc, busy, done, prog_err, overrun} !== 46'd0) begin
            errors++; $display("FAIL rstmid_outputs got %h exp 0", {instr_out, instr_valid, pc, busy, done, prog_err, overrun});
        end
        step(); step();
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy %b done %b exp 0 0", busy, done); end
        start(9'd4);
        for (int k = 1; k <= 9; k++) begin
            if (k >= 2 && k <= 5) begin
                checks++;
                if (instr_out !== words[k-2] || pc !== 8'(k-2)) begin
                    errors++; $display("FAIL rstmid_data k=%0d got %h pc %0d exp %h pc %0d", k, instr_out, pc, words[k-2], k-2);
                end
            end
            checks++;
            if (done !== (k == 7)) begin errors++; $display("FAIL rstmid_done k=%0d got %b exp %b", k, done, k == 7); end
            step();
        end
    endtask

    task automatic test_full_len();
        int nvalid;
        nvalid = 0;
        start(9'd256);
        for (int k = 1; k <= 262; k++) begin
            if (instr_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (pc !== 8'(k-2)) begin errors++; $display("FAIL full_pc k=%0d got %0d exp %0d", k, pc, k-2); end
            end
            checks++;
            if (done !== (k == 259)) begin errors++; $display("FAIL full_done k=%0d got %b exp %b", k, done, k == 259); end
            step();
        end
        checks++;
        if (nvalid != 256) begin errors++; $display("FAIL full_count got %0d exp 256", nvalid); end
        checks++;
        if (pc !== 8'd255) begin errors++; $display("FAIL full_pc_hold got %0d exp 255", pc); end
    endtask

    initial begin
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        words[3] = 32'h44; words[4] = 32'h55; words[5] = 32'h66;
        reset_n = 1'b0; sample_tick = 1'b0; n_instrs = 9'd0;
        prog_we = 1'b0; prog_addr = 8'd0; prog_data = 32'd0; stall = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_prog_err();
        test_write_tick();
        test_overrun();
        test_reset_mid();
        test_full_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Per-sample instruction sequencer for the block datapath.
- Holds the block program in an internal instruction RAM. On each sample tick it streams instructions 0..n_instrs-1, one per accepted cycle, into the instruction decoder, then signals completion.
- Also owns the program-load write port. Loads are allowed only while idle.

Parameters:
- INSTR_WIDTH, 32, instruction word width; matches the decoder input.
- ADDR_WIDTH, 8, program-counter / instruction RAM address width.
- DEPTH, 256, instruction RAM depth (2**ADDR_WIDTH).
- DRAIN_CYCLES, 2, cycles between final accept and done, covering decoder/datapath register stages.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle pulse; start of a new sample frame
- n_instrs  in  ADDR_WIDTH+1  program length, 0..DEPTH; latched on an accepted tick
- prog_we  in  1  instruction RAM write strobe
- prog_addr  in  ADDR_WIDTH  write address
- prog_data  in  INSTR_WIDTH  write data
- stall  in  1  datapath not ready; an instruction is accepted when instr_valid && !stall
- instr_out  out  INSTR_WIDTH  instruction presented to the decoder (registered)
- instr_valid  out  1  instr_out is valid
- pc  out  ADDR_WIDTH  index of the instruction currently on instr_out
- busy  out  1  high from the tick-accept cycle until the done cycle, inclusive
- done  out  1  one-cycle pulse at end of frame
- prog_err  out  1  one-cycle pulse: write rejected because busy
- overrun  out  1  sticky overrun flag (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 and state goes to IDLE, both immediately, including mid-frame. RAM contents are not cleared. No done pulse is generated for an aborted frame.
- Instruction RAM: synchronous, 1-cycle read latency. Single write port, single read port.
- States: IDLE, FETCH, RUN, DRAIN.
- IDLE:
  - prog_we writes RAM[prog_addr] <= prog_data.
  - On sample_tick: latch len = n_instrs and assert busy next cycle.
    - If len == 0: go to DRAIN.
    - Otherwise: go to FETCH with fetch address 0.
- FETCH (1 cycle): RAM read of address 0 is in flight. Then go to RUN.
- RUN:
  - instr_valid = 1, instr_out = RAM[pc].
  - First valid cycle is tick cycle T+2, with pc = 0.
  - Fetch-ahead: the read address is pc+1 when the current instruction is accepted, otherwise pc. A held instruction is therefore re-presented unchanged while stall = 1.
  - On accept with pc < len-1: pc increments and the next instruction appears the next cycle. Zero-bubble throughput: 1 instruction/cycle with stall low.
  - On accept with pc == len-1: instr_valid drops the next cycle and state goes to DRAIN. pc holds its last value.
  - pc never wraps. len == DEPTH runs addresses 0..DEPTH-1, then stops.
- DRAIN:
  - Counts DRAIN_CYCLES cycles with instr_valid = 0.
  - On the final count: done = 1 for one cycle, busy = 0 the following cycle, return to IDLE.
  - For len == 0, the drain still runs, so done occurs DRAIN_CYCLES+1 cycles after the tick.
- Latency, stall-free: tick at T → last instruction valid at T+1+len → done at T+2+len+DRAIN_CYCLES-1.
- prog_we while busy: write is dropped, prog_err pulses the next cycle, RAM unchanged.
- prog_we and tick in the same IDLE cycle: the write completes first and the frame sees the new word.
- sample_tick while busy: ignored; the frame continues undisturbed.
- n_instrs changes while busy: no effect; len is latched.
- stall in IDLE/FETCH/DRAIN: no effect.

Optional Feature:
- Macro: SEQ_OVERRUN_DETECT_EN.
- With the macro defined:
  - sample_tick while busy sets overrun (sticky). The current frame still completes; the tick is dropped.
  - overrun clears only on the next tick accepted in IDLE, so it stays visible for one full frame.
- Without the macro: overrun is tied to 0 and its logic is absent. All other behaviour is identical.

Test Plan:
- Load RAM[0..3] = 0x11,0x22,0x33,0x44. n_instrs = 4, stall = 0, tick at T → instr_valid T+2..T+5 with pc 0..3 and matching data; done at T+7; busy T+1..T+7.
- Same program with stall high for 3 cycles while pc = 1 → 0x22 held for 4 cycles, then 0x33 and 0x44 follow back-to-back; done delayed by exactly 3 cycles.
- n_instrs = 0, tick → no instr_valid; done at T+3; busy T+1..T+3.
- prog_we to addr 5 during RUN → prog_err pulse one cycle later; RAM[5] unchanged on the next frame.
- Second tick during RUN, macro defined → overrun = 1 after the tick, frame done timing unchanged; next idle tick clears overrun. Same stimulus without the macro → overrun stays 0.
- reset_n low while pc = 2 → outputs 0 and state IDLE immediately. A new tick after release runs from pc = 0 with RAM intact.
